// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory stage with an integrated load/store unit and a
// byte-addressed data RAM whose access latency is set by MEM_LATENCY (1..7).
module mem_stage_lsu #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 17,
  parameter int    MEM_LATENCY = 2,
  parameter string MEM_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  StallM,
  output logic                  ValidMout,
  output logic                  RegWriteMout,
  output logic [1:0]            ResultSrcMout,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic [4:0]            RdMout,
  output logic [DATA_WIDTH-1:0] PCPlus4Mout,
  output logic [DATA_WIDTH-1:0] ALUResultMout,
  output logic                  MisalignM
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [2:0]              r_cnt;
  logic [7:0]              r_mem [0:(1 << ADDR_WIDTH) - 1];

  logic                    r_regwrite;
  logic [1:0]              r_resultsrc;
  logic                    r_memread;
  logic [2:0]              r_funct3;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [4:0]              r_rd;
  logic [DATA_WIDTH-1:0]   r_pcplus4;
  logic [DATA_WIDTH-1:0]   r_rword;

  logic                    w_mem_op;
  logic                    w_illegal;
  logic                    w_misalign;
  logic                    w_fault;
  logic                    w_accept;
  logic                    w_we;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [ADDR_WIDTH-3:0]   w_word;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load_fmt;

  assign w_mem_op   = MemReadM | MemWriteM;
  // Illegal loads are funct3 3, 6, 7; illegal stores are funct3 above 2.
  assign w_illegal  = (MemReadM & MemWriteM)
                    | (MemReadM & ((funct3M[1:0] == 2'b11) | (funct3M == 3'b110)))
                    | (MemWriteM & (funct3M > 3'd2));
  assign w_misalign = ((funct3M[1:0] == 2'b01) & ALUResultM[0])
                    | ((funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
  assign w_fault    = ValidM & w_mem_op & (w_illegal | w_misalign);
  assign w_accept   = ValidM & w_mem_op & ~w_illegal & ~w_misalign & ~rst & (r_state == S_IDLE);
  assign w_we       = w_accept & MemWriteM;
  assign w_word     = ALUResultM[ADDR_WIDTH-1:2];

  // Store lane enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM byte writes commit on the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_we && w_be[k]) begin
        r_mem[{w_word, 2'(k)}] <= w_wdata[8*k +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = (LAT_M1 == 3'd0) ? S_DONE : S_BUSY;
        else          w_next_state = S_IDLE;
      end
      S_BUSY: begin
        if (r_cnt <= 3'd1) w_next_state = S_DONE;
        else               w_next_state = S_BUSY;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latency counter, instruction capture and load-word sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 3'd0;
      r_regwrite  <= 1'b0;
      r_resultsrc <= 2'd0;
      r_memread   <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_rd        <= 5'd0;
      r_pcplus4   <= '0;
      r_rword     <= '0;
    end else if (w_accept) begin
      r_cnt       <= LAT_M1;
      r_regwrite  <= RegWriteM;
      r_resultsrc <= ResultSrcM;
      r_memread   <= MemReadM;
      r_funct3    <= funct3M;
      r_addr      <= ALUResultM;
      r_rd        <= RdM;
      r_pcplus4   <= PCPlus4M;
      r_rword     <= {r_mem[{w_word, 2'd3}], r_mem[{w_word, 2'd2}],
                      r_mem[{w_word, 2'd1}], r_mem[{w_word, 2'd0}]};
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - 3'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Little-endian load formatting from the captured word.
  always_comb begin
    w_byte = r_rword[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? r_rword[31:16] : r_rword[15:0];
    case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_fmt = r_rword;
      3'b100:  w_load_fmt = {24'd0, w_byte};
      3'b101:  w_load_fmt = {16'd0, w_half};
      default: w_load_fmt = 32'd0;
    endcase
  end

  // FSM outputs; IDLE passes live inputs through, BUSY/DONE use the captured copy.
  always_comb begin
    StallM        = 1'b0;
    ValidMout     = 1'b0;
    RegWriteMout  = 1'b0;
    MisalignM     = 1'b0;
    ReadDataM     = 32'd0;
    ResultSrcMout = ResultSrcM;
    RdMout        = RdM;
    PCPlus4Mout   = PCPlus4M;
    ALUResultMout = ALUResultM;
    if (rst) begin
      StallM    = 1'b0;
      ValidMout = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            StallM = 1'b1;
          end else if (w_fault) begin
            ValidMout = 1'b1;
            MisalignM = 1'b1;
          end else if (ValidM && !w_mem_op) begin
            ValidMout    = 1'b1;
            RegWriteMout = RegWriteM;
          end else begin
            ValidMout = 1'b0;
          end
        end
        S_BUSY: begin
          StallM        = 1'b1;
          ResultSrcMout = r_resultsrc;
          RdMout        = r_rd;
          PCPlus4Mout   = r_pcplus4;
          ALUResultMout = r_addr;
        end
        S_DONE: begin
          ValidMout     = 1'b1;
          RegWriteMout  = r_regwrite;
          ReadDataM     = r_memread ? w_load_fmt : 32'd0;
          ResultSrcMout = r_resultsrc;
          RdMout        = r_rd;
          PCPlus4Mout   = r_pcplus4;
          ALUResultMout = r_addr;
        end
        default: begin
          StallM    = 1'b0;
          ValidMout = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven scoreboard bench for mem_stage_lsu, plus
// reset-abort and latency sequences on MEM_LATENCY 1, 2 and 7 instances.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, MemWriteM, MemReadM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  logic        StallM, ValidMout, RegWriteMout, MisalignM;
  logic [1:0]  ResultSrcMout;
  logic [31:0] ReadDataM, PCPlus4Mout, ALUResultMout;
  logic [4:0]  RdMout;

  logic        st1, v1, rw1, mis1, st7, v7, rw7, mis7;
  logic [1:0]  rs1, rs7;
  logic [31:0] rd1, pc1, alu1, rd7, pc7, alu7;
  logic [4:0]  dst1, dst7;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .funct3M(funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .StallM(StallM),
    .ValidMout(ValidMout), .RegWriteMout(RegWriteMout), .ResultSrcMout(ResultSrcMout),
    .ReadDataM(ReadDataM), .RdMout(RdMout), .PCPlus4Mout(PCPlus4Mout),
    .ALUResultMout(ALUResultMout), .MisalignM(MisalignM));

  mem_stage_lsu #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .funct3M(funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .StallM(st1),
    .ValidMout(v1), .RegWriteMout(rw1), .ResultSrcMout(rs1), .ReadDataM(rd1),
    .RdMout(dst1), .PCPlus4Mout(pc1), .ALUResultMout(alu1), .MisalignM(mis1));

  mem_stage_lsu #(.MEM_LATENCY(7)) dut7 (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .funct3M(funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .StallM(st7),
    .ValidMout(v7), .RegWriteMout(rw7), .ResultSrcMout(rs7), .ReadDataM(rd7),
    .RdMout(dst7), .PCPlus4Mout(pc7), .ALUResultMout(alu7), .MisalignM(mis7));

  typedef struct {
    logic        we, re;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        rw;
    int          stall;
    logic [31:0] rdata;
    logic        mis, rwout;
  } vec_t;

  typedef struct {
    logic [31:0] rdata, alu, pc;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic        rw, mis;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[22];

  function automatic vec_t mk(input logic we, input logic re, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic rw, input int stall,
                              input logic [31:0] rdata, input logic mis, input logic rwout);
    vec_t v;
    v.we = we; v.re = re; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rw = rw;
    v.stall = stall; v.rdata = rdata; v.mis = mis; v.rwout = rwout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction, push its expectation, hold it until the stage releases it.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, g;
    int   stalls = 0;
    bit   done = 1'b0;
    ValidM = 1'b1; MemWriteM = v.we; MemReadM = v.re; funct3M = v.f3;
    ALUResultM = v.addr; WriteDataM = v.wdata; RdM = v.rd; RegWriteM = v.rw;
    ResultSrcM = 2'(idx); PCPlus4M = 32'h1000 + 32'(4 * idx);
    e.rdata = v.rdata; e.alu = v.addr; e.pc = PCPlus4M; e.rd = v.rd; e.rs = ResultSrcM;
    e.rw = v.rwout; e.mis = v.mis;
    sb_q.push_back(e);
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (StallM) stalls++;
      if (ValidMout && StallM) chk($sformatf("v%0d_valid_while_stall", idx), 32'd1, 32'd0);
      if (ValidMout) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d_unexpected_valid", idx), 32'd1, 32'd0);
        end else begin
          g = sb_q.pop_front();
          chk($sformatf("v%0d_rdata", idx), ReadDataM, g.rdata);
          chk($sformatf("v%0d_mis", idx), 32'(MisalignM), 32'(g.mis));
          chk($sformatf("v%0d_regwrite", idx), 32'(RegWriteMout), 32'(g.rw));
          chk($sformatf("v%0d_rd", idx), 32'(RdMout), 32'(g.rd));
          chk($sformatf("v%0d_alu", idx), ALUResultMout, g.alu);
          chk($sformatf("v%0d_pc4", idx), PCPlus4Mout, g.pc);
          chk($sformatf("v%0d_rsrc", idx), 32'(ResultSrcMout), 32'(g.rs));
        end
      end
      if (!StallM) done = 1'b1;
      tick();
    end
    if (!done) chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);
    chk($sformatf("v%0d_stall_len", idx), 32'(stalls), 32'(v.stall));
    if (sb_q.size() != 0) begin
      chk($sformatf("v%0d_no_output", idx), 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    int s1, s2, s7, c1, c2, c7, d1, d2, d7;
    // we re f3 addr wdata rd rw stall rdata mis rwout
    tbl[0]  = mk(1, 0, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 0, 2, 32'h0,        0, 0);
    tbl[1]  = mk(0, 1, 3'd2, 32'h100, 32'h0,        5'd1, 1, 2, 32'hDEADBEEF, 0, 1);
    tbl[2]  = mk(1, 0, 3'd2, 32'h200, 32'h80007F80, 5'd0, 0, 2, 32'h0,        0, 0);
    tbl[3]  = mk(0, 1, 3'd0, 32'h200, 32'h0,        5'd2, 1, 2, 32'hFFFFFF80, 0, 1);
    tbl[4]  = mk(0, 1, 3'd4, 32'h200, 32'h0,        5'd3, 1, 2, 32'h00000080, 0, 1);
    tbl[5]  = mk(0, 1, 3'd0, 32'h201, 32'h0,        5'd4, 1, 2, 32'h0000007F, 0, 1);
    tbl[6]  = mk(0, 1, 3'd1, 32'h202, 32'h0,        5'd6, 1, 2, 32'hFFFF8000, 0, 1);
    tbl[7]  = mk(0, 1, 3'd5, 32'h202, 32'h0,        5'd7, 1, 2, 32'h00008000, 0, 1);
    tbl[8]  = mk(1, 0, 3'd0, 32'h103, 32'h000000AA, 5'd0, 0, 2, 32'h0,        0, 0);
    tbl[9]  = mk(0, 1, 3'd2, 32'h100, 32'h0,        5'd8, 1, 2, 32'hAAADBEEF, 0, 1);
    tbl[10] = mk(1, 0, 3'd1, 32'h102, 32'hABCD1234, 5'd0, 0, 2, 32'h0,        0, 0);
    tbl[11] = mk(0, 1, 3'd2, 32'h100, 32'h0,        5'd9, 1, 2, 32'h1234BEEF, 0, 1);
    tbl[12] = mk(0, 1, 3'd2, 32'h102, 32'h0,        5'd10, 1, 0, 32'h0,       1, 0);
    tbl[13] = mk(1, 0, 3'd1, 32'h101, 32'h0000FFFF, 5'd0, 0, 0, 32'h0,        1, 0);
    tbl[14] = mk(0, 1, 3'd2, 32'h100, 32'h0,        5'd11, 1, 2, 32'h1234BEEF, 0, 1);
    tbl[15] = mk(0, 1, 3'd1, 32'h100, 32'h0,        5'd12, 1, 2, 32'hFFFFBEEF, 0, 1);
    tbl[16] = mk(0, 1, 3'd4, 32'h103, 32'h0,        5'd13, 1, 2, 32'h00000012, 0, 1);
    tbl[17] = mk(0, 0, 3'd0, 32'h55,  32'h0,        5'd5, 1, 0, 32'h0,        0, 1);
    tbl[18] = mk(0, 1, 3'd3, 32'h100, 32'h0,        5'd14, 1, 0, 32'h0,       1, 0);
    tbl[19] = mk(0, 1, 3'd6, 32'h100, 32'h0,        5'd15, 1, 0, 32'h0,       1, 0);
    tbl[20] = mk(1, 0, 3'd4, 32'h100, 32'h0,        5'd0, 0, 0, 32'h0,        1, 0);
    tbl[21] = mk(1, 1, 3'd2, 32'h100, 32'h0,        5'd16, 1, 0, 32'h0,       1, 0);

    rst = 1'b1; ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2;
    ALUResultM = 32'h100; WriteDataM = 32'h0; RdM = 5'd1; RegWriteM = 1'b1;
    ResultSrcM = 2'd1; PCPlus4M = 32'h4;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_valid", 32'(ValidMout), 32'd0);
    chk("rst_regwrite", 32'(RegWriteMout), 32'd0);
    chk("rst_mis", 32'(MisalignM), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    tick();
    ValidM = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_bubble_valid", 32'(ValidMout), 32'd0);
    chk("idle_bubble_stall", 32'(StallM), 32'd0);
    tick();

    for (int i = 0; i < 22; i++) run_vec(tbl[i], i);
    ValidM = 1'b0;
    tick();

    // Reset during BUSY aborts the load; nothing reaches W.
    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2;
    ALUResultM = 32'h100; RdM = 5'd20; RegWriteM = 1'b1;
    @(negedge clk);
    chk("abort_accept_stall", 32'(StallM), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_stall", 32'(StallM), 32'd0);
    chk("abort_rst_valid", 32'(ValidMout), 32'd0);
    chk("abort_rst_regwrite", 32'(RegWriteMout), 32'd0);
    tick();
    rst = 1'b0; ValidM = 1'b0;
    @(negedge clk);
    chk("abort_after_stall", 32'(StallM), 32'd0);
    chk("abort_after_valid", 32'(ValidMout), 32'd0);
    tick();
    run_vec(mk(0, 1, 3'd2, 32'h100, 32'h0, 5'd21, 1, 2, 32'h1234BEEF, 0, 1), 30);
    ValidM = 1'b0;
    repeat (10) tick();

    // One-cycle lw into all three latency variants; stall length must equal MEM_LATENCY.
    s1 = 0; s2 = 0; s7 = 0; c1 = 0; c2 = 0; c7 = 0; d1 = -1; d2 = -1; d7 = -1;
    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2; ALUResultM = 32'h100;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (st1) s1++;
      if (StallM) s2++;
      if (st7) s7++;
      if (v1) begin c1++; d1 = c; end
      if (ValidMout) begin c2++; d2 = c; end
      if (v7) begin c7++; d7 = c; end
      tick();
      ValidM = 1'b0;
    end
    chk("lat1_stall_len", 32'(s1), 32'd1);
    chk("lat2_stall_len", 32'(s2), 32'd2);
    chk("lat7_stall_len", 32'(s7), 32'd7);
    chk("lat1_valid_cnt", 32'(c1), 32'd1);
    chk("lat2_valid_cnt", 32'(c2), 32'd1);
    chk("lat7_valid_cnt", 32'(c7), 32'd1);
    chk("lat1_done_cycle", 32'(d1), 32'd1);
    chk("lat2_done_cycle", 32'(d2), 32'd2);
    chk("lat7_done_cycle", 32'(d7), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
